// File: rtl/serial_mag_comp_pkg.sv
// Shared types and helpers for the serial magnitude comparator.
package comp_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} cmp_state_t;
    typedef enum logic [1:0] {CMP_EQ, CMP_GT, CMP_LT} cmp_res_t;

    localparam int unsigned DEF_WIDTH   = 16;
    localparam int unsigned DEF_DIGIT_W = 4;

    // Digit counter width; a single-digit compare still needs one bit.
    function automatic int unsigned cnt_width(input int unsigned ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

endpackage

// File: rtl/serial_mag_comp_if.sv
// Operand/result handshake bundle between a requester and the serial comparator.
interface serial_mag_comp_if
    import comp_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;
    logic             res_valid;
    logic             res_ready;
    logic             GT;
    logic             LT;
    logic             EQ;
    logic             busy;

    modport master (
        output in_valid, a, b, signed_mode, res_ready,
        input  in_ready, res_valid, GT, LT, EQ, busy
    );

    modport slave (
        input  in_valid, a, b, signed_mode, res_ready,
        output in_ready, res_valid, GT, LT, EQ, busy
    );
endinterface

// File: rtl/serial_mag_comp_digit_cmp.sv
// Combinational unsigned compare of one digit.
module digit_cmp #(
    parameter int unsigned DIGIT_W = 4
) (
    input  logic [DIGIT_W-1:0] x,
    input  logic [DIGIT_W-1:0] y,
    output logic               gt,
    output logic               lt
);
    assign gt = (x > y);
    assign lt = (x < y);
endmodule

// File: rtl/serial_mag_comp.sv
// Multi-cycle MSB-first magnitude comparator with early exit on the first unequal digit.
module serial_mag_comp
    import comp_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned DIGIT_W = DEF_DIGIT_W
) (
    input logic             clk,
    input logic             rst,
    serial_mag_comp_if.slave bus
);
    localparam int unsigned         NDIG      = WIDTH / DIGIT_W;
    localparam int unsigned         CW        = cnt_width(NDIG);
    localparam logic [CW-1:0]       CNT_TOP   = CW'(NDIG - 1);
    localparam logic [DIGIT_W-1:0]  SIGN_FLIP = DIGIT_W'(1) << (DIGIT_W - 1);

    if ((WIDTH % DIGIT_W) != 0 || WIDTH < DIGIT_W) begin : g_bad_cfg
        $error("serial_mag_comp: WIDTH must be a non-zero multiple of DIGIT_W");
    end

    cmp_state_t       state_q, state_n;
    logic [CW-1:0]    cnt_q, cnt_n;
    logic [WIDTH-1:0] a_q, a_n, b_q, b_n;
    logic             mode_q, mode_n;
    logic             in_ready_q, in_ready_n;
    logic             busy_q, busy_n;
    logic             res_valid_q, res_valid_n;
    logic             gt_q, gt_n, lt_q, lt_n, eq_q, eq_n;

    logic [DIGIT_W-1:0] dig_a, dig_b;
    logic               dig_gt, dig_lt;

    // Digit select; the top digit is shifted to offset binary in signed mode.
    always_comb begin
        dig_a = '0;
        dig_b = '0;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (cnt_q == CW'(i)) begin
                dig_a = a_q[i*DIGIT_W +: DIGIT_W];
                dig_b = b_q[i*DIGIT_W +: DIGIT_W];
            end
        end
        if (mode_q && cnt_q == CNT_TOP) begin
            dig_a = dig_a ^ SIGN_FLIP;
            dig_b = dig_b ^ SIGN_FLIP;
        end
    end

    digit_cmp #(.DIGIT_W(DIGIT_W)) u_digit_cmp (
        .x  (dig_a),
        .y  (dig_b),
        .gt (dig_gt),
        .lt (dig_lt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= CNT_TOP;
            a_q         <= '0;
            b_q         <= '0;
            mode_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            gt_q        <= 1'b0;
            lt_q        <= 1'b0;
            eq_q        <= 1'b0;
        end else begin
            state_q     <= state_n;
            cnt_q       <= cnt_n;
            a_q         <= a_n;
            b_q         <= b_n;
            mode_q      <= mode_n;
            in_ready_q  <= in_ready_n;
            busy_q      <= busy_n;
            res_valid_q <= res_valid_n;
            gt_q        <= gt_n;
            lt_q        <= lt_n;
            eq_q        <= eq_n;
        end
    end

    cmp_res_t res;
    logic     finish;

    always_comb begin
        state_n     = state_q;
        cnt_n       = cnt_q;
        a_n         = a_q;
        b_n         = b_q;
        mode_n      = mode_q;
        in_ready_n  = in_ready_q;
        busy_n      = busy_q;
        res_valid_n = res_valid_q;
        gt_n        = gt_q;
        lt_n        = lt_q;
        eq_n        = eq_q;
        res         = CMP_EQ;
        finish      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    state_n    = RUN;
                    a_n        = bus.a;
                    b_n        = bus.b;
                    mode_n     = bus.signed_mode;
                    cnt_n      = CNT_TOP;
                    in_ready_n = 1'b0;
                    busy_n     = 1'b1;
                end
            end
            RUN: begin
                if (dig_gt || dig_lt) begin
                    res    = dig_gt ? CMP_GT : CMP_LT;
                    finish = 1'b1;
                end else if (cnt_q == '0) begin
                    res    = CMP_EQ;
                    finish = 1'b1;
                end else begin
                    cnt_n = cnt_q - CW'(1);
                end
                if (finish) begin
                    state_n     = DONE;
                    res_valid_n = 1'b1;
                    gt_n        = (res == CMP_GT);
                    lt_n        = (res == CMP_LT);
                    eq_n        = (res == CMP_EQ);
                end
            end
            DONE: begin
                // Pop returns to IDLE; accept is only possible from the following cycle.
                if (bus.res_ready) begin
                    state_n     = IDLE;
                    res_valid_n = 1'b0;
                    gt_n        = 1'b0;
                    lt_n        = 1'b0;
                    eq_n        = 1'b0;
                    in_ready_n  = 1'b1;
                    busy_n      = 1'b0;
                end
            end
            default: begin
                state_n     = IDLE;
                in_ready_n  = 1'b1;
                busy_n      = 1'b0;
                res_valid_n = 1'b0;
                gt_n        = 1'b0;
                lt_n        = 1'b0;
                eq_n        = 1'b0;
            end
        endcase
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.busy      = busy_q;
    assign bus.res_valid = res_valid_q;
    assign bus.GT        = gt_q;
    assign bus.LT        = lt_q;
    assign bus.EQ        = eq_q;

endmodule

// File: tb/tb_serial_mag_comp.sv
// Bench for serial_mag_comp: 16-bit/4-bit-digit and 4-bit/1-bit-digit instances against an arithmetic model.
module tb_serial_mag_comp;
    import comp_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serial_mag_comp_if #(.WIDTH(16)) b16 ();
    serial_mag_comp_if #(.WIDTH(4))  b4 ();

    serial_mag_comp #(.WIDTH(16), .DIGIT_W(4)) dut16 (.clk(clk), .rst(rst), .bus(b16));
    serial_mag_comp #(.WIDTH(4),  .DIGIT_W(1)) dut4  (.clk(clk), .rst(rst), .bus(b4));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected {GT,LT,EQ} from plain integer comparison of the operand values.
    function automatic logic [2:0] exp_flags(input logic [15:0] a, input logic [15:0] b,
                                             input logic sm, input int w);
        longint va, vb;
        va = longint'(a) & ((longint'(1) << w) - 1);
        vb = longint'(b) & ((longint'(1) << w) - 1);
        if (sm && a[w-1]) va = va - (longint'(1) << w);
        if (sm && b[w-1]) vb = vb - (longint'(1) << w);
        if (va > vb) return 3'b100;
        if (va < vb) return 3'b010;
        return 3'b001;
    endfunction

    // Expected cycles from accept to result: position of the highest differing digit.
    function automatic int exp_lat(input logic [15:0] a, input logic [15:0] b, input int w, input int dw);
        int nd, d;
        nd = w / dw;
        d  = int'(a ^ b);
        for (int k = nd - 1; k >= 0; k--) begin
            if (((d >> (k * dw)) & ((1 << dw) - 1)) != 0) return nd - k;
        end
        return nd;
    endfunction

    task automatic txn16(input logic [15:0] a, input logic [15:0] b, input logic sm,
                         input int hold, input string tag);
        int n;
        logic got;
        logic [2:0] ef;
        ef = exp_flags(a, b, sm, 16);
        @(negedge clk);
        check({tag, " in_ready"}, 32'(b16.in_ready), 32'd1);
        b16.in_valid = 1'b1; b16.a = a; b16.b = b; b16.signed_mode = sm;
        @(posedge clk);
        @(negedge clk);
        b16.in_valid = 1'b0; b16.a = 16'($urandom); b16.b = 16'($urandom); b16.signed_mode = ~sm;
        check({tag, " busy"}, 32'({b16.busy, b16.in_ready}), 32'b10);
        n = 0; got = 1'b0;
        while (!got && n < 8) begin
            @(posedge clk); n++;
            @(negedge clk); got = b16.res_valid;
        end
        check({tag, " latency"}, 32'(n), 32'(exp_lat(a, b, 16, 4)));
        check({tag, " flags"}, 32'({b16.GT, b16.LT, b16.EQ}), 32'(ef));
        for (int i = 0; i < hold; i++) begin
            b16.in_valid = ~b16.in_valid; b16.a = 16'($urandom); b16.b = 16'($urandom);
            @(posedge clk);
            @(negedge clk);
            check({tag, " hold"}, 32'({b16.res_valid, b16.in_ready, b16.GT, b16.LT, b16.EQ}),
                  32'({2'b10, ef}));
        end
        b16.in_valid = 1'b0;
        b16.res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b16.res_ready = 1'b0;
        check({tag, " pop"}, 32'({b16.res_valid, b16.in_ready, b16.busy, b16.GT, b16.LT, b16.EQ}),
              32'b010000);
    endtask

    task automatic txn4(input logic [3:0] a, input logic [3:0] b, input logic sm);
        int n;
        logic got;
        @(negedge clk);
        b4.in_valid = 1'b1; b4.a = a; b4.b = b; b4.signed_mode = sm;
        @(posedge clk);
        @(negedge clk);
        b4.in_valid = 1'b0;
        n = 0; got = 1'b0;
        while (!got && n < 8) begin
            @(posedge clk); n++;
            @(negedge clk); got = b4.res_valid;
        end
        check($sformatf("w4 a=%0h b=%0h s=%0d", a, b, sm), 32'({n[3:0], b4.GT, b4.LT, b4.EQ}),
              32'({4'(exp_lat({12'h0, a}, {12'h0, b}, 4, 1)), exp_flags({12'h0, a}, {12'h0, b}, sm, 4)}));
        b4.res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b4.res_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] ra, rb;
        int k;
        b16.in_valid = 1'b0; b16.a = '0; b16.b = '0; b16.signed_mode = 1'b0; b16.res_ready = 1'b0;
        b4.in_valid  = 1'b0; b4.a  = '0; b4.b  = '0; b4.signed_mode  = 1'b0; b4.res_ready  = 1'b0;

        // Reset values, then a second reset mid-idle with in_valid held low
        repeat (2) @(negedge clk);
        check("reset", 32'({b16.in_ready, b16.res_valid, b16.GT, b16.LT, b16.EQ, b16.busy}), 32'b100000);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1 check("reset idle", 32'({b16.in_ready, b16.res_valid, b16.GT, b16.LT, b16.EQ, b16.busy}),
                 32'b100000);
        @(negedge clk) rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle hold", 32'({b16.in_ready, b16.res_valid, b16.GT, b16.LT, b16.EQ, b16.busy}), 32'b100000);

        // Directed cases
        txn16(16'h1234, 16'h1234, 1'b0, 0, "eq1234");
        txn16(16'h8000, 16'h7FFF, 1'b0, 0, "u8000");
        txn16(16'h8000, 16'h7FFF, 1'b1, 0, "s8000");
        txn16(16'h00A5, 16'h00A6, 1'b0, 0, "u00A5");
        txn16(16'hFFFF, 16'h0001, 1'b1, 0, "sFFFF");
        txn16(16'h4321, 16'h4322, 1'b1, 5, "bkpr");
        txn16(16'h0F00, 16'h0E00, 1'b0, 0, "after_bkpr");

        // Reset pulse during the second RUN cycle of an equal compare
        @(negedge clk);
        b16.in_valid = 1'b1; b16.a = 16'h1234; b16.b = 16'h1234; b16.signed_mode = 1'b0;
        @(posedge clk);
        @(negedge clk);
        b16.in_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check("rst_run", 32'({b16.in_ready, b16.res_valid, b16.GT, b16.LT, b16.EQ, b16.busy}), 32'b100000);
        @(negedge clk) rst = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_discard", 32'({b16.in_ready, b16.res_valid, b16.GT, b16.LT, b16.EQ, b16.busy}),
              32'b100000);

        // Randomized 16-bit pairs, biased so the first difference lands in a random digit
        for (int i = 0; i < 60; i++) begin
            ra = 16'($urandom);
            rb = ra;
            k  = int'($urandom_range(0, 4));
            if (k < 4) rb = ra ^ (16'($urandom_range(1, 15)) << (4 * k));
            txn16(ra, rb, 1'($urandom), (i % 10 == 0) ? 2 : 0, $sformatf("rnd%0d", i));
        end

        // Exhaustive 4-bit sweep with one-bit digits, both modes
        for (int s = 0; s < 2; s++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    txn4(4'(x), 4'(y), 1'(s));
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
